hypot_iter: RTL and testbench

- Parametrised, handshaked successor to the combinational add-on magnitude unit.
- Computes the integer magnitude sqrt(x^2 + y^2) of two unsigned operands with a multi-cycle digit-by-digit square-root engine, one result bit per cycle.
- Supports selectable floor or round-to-nearest output and an exactness flag.
- Sits between the pin-level wrapper and user logic, with valid/ready on both sides.

---
 rtl/hypot_iter.sv | 125 ++++++++++++
 tb/tb_hypot_iter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hypot_iter.sv
// hypot_iter: handshaked integer magnitude sqrt(x^2+y^2)
// digit-by-digit root, one result bit per cycle
module hypot_iter #(
  parameter int WIDTH      = 8,
  parameter int ROUND_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   mag,
  output logic             exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int R  = WIDTH + 1;
  localparam int RW = R + 2;
  localparam int CW = $clog2(R);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [2*R-1:0]  sr;
  logic [R-1:0]    root;
  logic [R-1:0]    rem;
  logic [CW-1:0]   cnt;

  logic [2*R-1:0]  xe;
  logic [2*R-1:0]  ye;
  logic [2*R-1:0]  sum_w;
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;
  logic [RW-1:0]   rem_nx;
  logic [R-1:0]    root_nx;
  logic            ge;
  logic            round_up;
  logic [R-1:0]    mag_nx;

  // sum of squares and one root digit step
  always_comb begin
    xe       = {{(2*R-WIDTH){1'b0}}, xr};
    ye       = {{(2*R-WIDTH){1'b0}}, yr};
    sum_w    = xe * xe + ye * ye;
    rem_sh   = {rem, sr[2*R-1:2*R-2]};
    trial    = {root, 2'b01};
    ge       = (rem_sh >= trial);
    rem_nx   = ge ? (rem_sh - trial) : rem_sh;
    root_nx  = {root[R-2:0], ge};
    round_up = (ROUND_MODE == 1) &&
               (rem_nx > {2'b00, root_nx});
    mag_nx   = root_nx + {{(R-1){1'b0}}, round_up};
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mag       <= '0;
      exact     <= 1'b0;
      xr        <= '0;
      yr        <= '0;
      sr        <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xr       <= x;
            yr       <= y;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SQUARE;
          end
        end
        SQUARE: begin
          sr    <= sum_w;
          root  <= '0;
          rem   <= '0;
          cnt   <= CW'(R - 1);
          state <= ROOT;
        end
        ROOT: begin
          sr   <= sr << 2;
          root <= root_nx;
          rem  <= rem_nx[R-1:0];
          if (cnt == '0) begin
            mag       <= mag_nx;
            exact     <= (rem_nx == '0);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hypot_iter.sv
// tb_hypot_iter: table vectors, corner sequences
// and a random WIDTH=16 sweep against a sqrt model
module tb_hypot_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic out_ready = 1'b1;
  logic [7:0] x8 = '0, y8 = '0;
  logic [15:0] x16 = '0, y16 = '0;
  logic iv8 = 1'b0, iv16 = 1'b0;

  logic ir8f, ex8f, ov8f, bz8f;
  logic ir8r, ex8r, ov8r, bz8r;
  logic [8:0] mg8f, mg8r;
  logic ir16f, ex16f, ov16f, bz16f;
  logic ir16r, ex16r, ov16r, bz16r;
  logic [16:0] mg16f, mg16r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hypot_iter #(.WIDTH(8), .ROUND_MODE(0)) u8f (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x8), .y(y8), .in_valid(iv8),
    .in_ready(ir8f), .mag(mg8f), .exact(ex8f),
    .out_valid(ov8f), .out_ready(out_ready),
    .busy(bz8f));

  hypot_iter #(.WIDTH(8), .ROUND_MODE(1)) u8r (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x8), .y(y8), .in_valid(iv8),
    .in_ready(ir8r), .mag(mg8r), .exact(ex8r),
    .out_valid(ov8r), .out_ready(out_ready),
    .busy(bz8r));

  hypot_iter #(.WIDTH(16), .ROUND_MODE(0)) u16f (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x16), .y(y16), .in_valid(iv16),
    .in_ready(ir16f), .mag(mg16f), .exact(ex16f),
    .out_valid(ov16f), .out_ready(out_ready),
    .busy(bz16f));

  hypot_iter #(.WIDTH(16), .ROUND_MODE(1)) u16r (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .x(x16), .y(y16), .in_valid(iv16),
    .in_ready(ir16r), .mag(mg16r), .exact(ex16r),
    .out_valid(ov16r), .out_ready(out_ready),
    .busy(bz16r));

  typedef struct {
    int x;
    int y;
    int mf;
    int mr;
    int ex;
  } vec_t;

  vec_t tv[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint isqrt(longint s);
    longint lo = 0;
    longint hi = 1 << 18;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint iround(longint s);
    longint r = isqrt(s);
    // (r+0.5)^2 = r^2 + r + 0.25
    return (s - r * r > r) ? r + 1 : r;
  endfunction

  // accept one 8-bit op, wait for out_valid; ena
  // forced low for cycles [fa, fa+fl) after acceptance
  task automatic op8(input int a, input int b,
                     input int fa, input int fl,
                     output int lat, output bit bad);
    chk("ready_before_accept", ir8f, 1);
    x8 = a[7:0];
    y8 = b[7:0];
    iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    lat = 0;
    bad = 0;
    while (!ov8f && lat < 200) begin
      ena = (lat >= fa && lat < fa + fl) ? 1'b0 : 1'b1;
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      if (ir8f || !bz8f) bad = 1;
      step();
      lat++;
    end
    ena = 1'b1;
    if (ir8f || bz8f) bad = 1;
  endtask

  task automatic op16(input int a, input int b,
                      output int lat, output bit bad);
    x16 = a[15:0];
    y16 = b[15:0];
    iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    lat = 0;
    bad = 0;
    while (!ov16f && lat < 200) begin
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      if (ir16f || !bz16f) bad = 1;
      step();
      lat++;
    end
    if (ir16f || bz16f) bad = 1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_in_ready"}, ir8f, 1);
    chk({nm, "_out_valid"}, ov8f, 0);
    chk({nm, "_busy"}, bz8f, 0);
    chk({nm, "_mag"}, mg8f, 0);
    chk({nm, "_exact"}, ex8f, 0);
    chk({nm, "_mag_r"}, mg8r, 0);
  endtask

  initial begin
    int lat;
    bit bad;
    longint s;
    int a, b;

    tv[0] = '{3, 4, 5, 5, 1};
    tv[1] = '{7, 24, 25, 25, 1};
    tv[2] = '{10, 15, 18, 18, 0};
    tv[3] = '{255, 255, 360, 361, 0};
    tv[4] = '{0, 0, 0, 0, 1};
    tv[5] = '{6, 8, 10, 10, 1};
    tv[6] = '{1, 1, 1, 1, 0};
    tv[7] = '{2, 3, 3, 4, 0};
    tv[8] = '{255, 0, 255, 255, 1};
    tv[9] = '{1, 2, 2, 2, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk_reset("reset");

    for (int i = 0; i < 10; i++) begin
      op8(tv[i].x, tv[i].y, -1, 0, lat, bad);
      chk("lat8", lat, 10);
      chk("mag8_floor", mg8f, tv[i].mf);
      chk("mag8_round", mg8r, tv[i].mr);
      chk("exact8_floor", ex8f, tv[i].ex);
      chk("exact8_round", ex8r, tv[i].ex);
      chk("ready_busy_during_op", bad, 0);
      step();
      chk("drain_out_valid", ov8f, 0);
      chk("drain_in_ready", ir8f, 1);
    end

    // backpressure: hold result 20 cycles, junk input
    out_ready = 1'b0;
    op8(2, 3, -1, 0, lat, bad);
    chk("bp_lat", lat, 10);
    for (int i = 0; i < 20; i++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      iv8 = 1'($urandom);
      step();
      chk("bp_out_valid", ov8f, 1);
      chk("bp_mag_floor", mg8f, 3);
      chk("bp_mag_round", mg8r, 4);
      chk("bp_exact", ex8f, 0);
      chk("bp_in_ready", ir8f, 0);
    end
    iv8 = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", ov8f, 0);
    chk("bp_release_ready", ir8f, 1);
    step();
    step();
    chk("bp_no_phantom_busy", bz8f, 0);
    chk("bp_no_phantom_valid", ov8f, 0);

    // clock enable low for 5 cycles mid-ROOT
    op8(12, 5, 4, 5, lat, bad);
    chk("ena_lat", lat, 15);
    chk("ena_mag_floor", mg8f, 13);
    chk("ena_mag_round", mg8r, 13);
    chk("ena_exact", ex8f, 1);
    step();
    chk("ena_drain", ov8f, 0);

    // asynchronous reset mid-ROOT
    x8 = 8'd9;
    y8 = 8'd12;
    iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", bz8f, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    step();
    op8(6, 8, -1, 0, lat, bad);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_mag", mg8f, 10);
    chk("post_rst_exact", ex8f, 1);
    step();

    // WIDTH=16 random sweep
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        a = 65535;
        b = 65535;
      end else if (i == 1) begin
        a = 0;
        b = 0;
      end else begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(0, 65535);
      end
      s = longint'(a) * a + longint'(b) * b;
      op16(a, b, lat, bad);
      chk("lat16", lat, 18);
      chk("mag16_floor", mg16f, isqrt(s));
      chk("mag16_round", mg16r, iround(s));
      chk("exact16", ex16f,
          (isqrt(s) * isqrt(s) == s) ? 1 : 0);
      chk("exact16_round", ex16r,
          (isqrt(s) * isqrt(s) == s) ? 1 : 0);
      chk("flags16", bad, 0);
      step();
      chk("drain16", ov16f, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
